svreal_mul_scheduler: RTL and testbench

//  Shares one pipelined svreal fixed-point multiplier among N_REQ requesters.

---
 rtl/svreal_sched_pkg.sv | 17 +
 rtl/svreal_mul_scheduler_if.sv | 30 +++
 rtl/svreal_rr_arbiter.sv | 41 ++++
 rtl/svreal_mul_scheduler.sv | 126 ++++++++++++
 tb/tb_svreal_mul_scheduler.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/svreal_sched_pkg.sv
// Shared helpers for the svreal multiplier scheduler: tag width and fixed-point alignment.
// Latency: none (elaboration-time functions only).
// Backpressure: not applicable.
package svreal_sched_pkg;

  // Requester index width; never below one bit so a tag field always exists.
  function automatic int tag_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  // Right-shift amount that moves a product with exponent ea+eb onto exponent ec.
  // Negative means a left shift.
  function automatic int align_shift(input int ea, input int eb, input int ec);
    return ec - (ea + eb);
  endfunction

endpackage

// File: rtl/svreal_mul_scheduler_if.sv
// Request/response bundle between N_REQ requesters and the shared multiplier.
// Latency: wires only.
// Backpressure: req_ready is the only flow control; responses cannot be stalled.
//   master: drives en, req_valid, req_a, req_b; observes req_ready, resp_valid, resp_c, busy
//   slave : the scheduler side
interface svreal_mul_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int WA    = 16,
  parameter int WB    = 16,
  parameter int WC    = 16
);
  logic                 en;
  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ-1:0]     req_ready;
  logic [N_REQ*WA-1:0]  req_a;
  logic [N_REQ*WB-1:0]  req_b;
  logic [N_REQ-1:0]     resp_valid;
  logic [WC-1:0]        resp_c;
  logic                 busy;

  modport master (
    output en, req_valid, req_a, req_b,
    input  req_ready, resp_valid, resp_c, busy
  );

  modport slave (
    input  en, req_valid, req_a, req_b,
    output req_ready, resp_valid, resp_c, busy
  );
endinterface

// File: rtl/svreal_rr_arbiter.sv
// Round-robin one-hot grant; scans upward from ptr_i+1 and wraps.
// Latency: purely combinational; the pointer register lives in the parent.
// Backpressure: grants only requesters that assert req_i, and none when en_i=0.
//   req_i     requester valid bits      gnt_o     one-hot grant
//   en_i      grant enable              gnt_idx_o index of the granted requester
//   ptr_i     last granted index        any_gnt_o a grant was issued
module svreal_rr_arbiter
  import svreal_sched_pkg::*;
#(
  parameter int N = 4,
  localparam int TW = tag_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic          en_i,
  input  logic [TW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [TW-1:0] gnt_idx_o,
  output logic          any_gnt_o
);

  int idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_gnt_o = 1'b0;
    idx       = 0;
    if (en_i) begin
      // k runs 1..N so the last-granted requester is considered last.
      for (int k = 1; k <= N; k++) begin
        idx = (int'(ptr_i) + k) % N;
        if (!any_gnt_o && req_i[idx]) begin
          gnt_o[idx] = 1'b1;
          gnt_idx_o  = TW'(idx);
          any_gnt_o  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/svreal_mul_scheduler.sv
// Time-shares one pipelined svreal fixed-point multiplier among N_REQ requesters.
// Latency: result pulses on resp_valid[tag] MUL_LAT cycles after the grant cycle.
// Backpressure: round-robin req_ready grant, at most one per cycle; pipeline never stalls.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of svreal_mul_scheduler_if (en, req_*, resp_*, busy)
module svreal_mul_scheduler
  import svreal_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WA      = 16,
  parameter int EA      = -8,
  parameter int WB      = 16,
  parameter int EB      = -8,
  parameter int WC      = 16,
  parameter int EC      = -8,
  parameter int MUL_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  svreal_mul_scheduler_if.slave   bus
);

  localparam int TW    = tag_w(N_REQ);
  localparam int PW    = WA + WB;
  localparam int SHIFT = align_shift(EA, EB, EC);
  localparam int SHR   = (SHIFT >= 0) ? SHIFT : 0;
  localparam int SHL   = (SHIFT < 0) ? -SHIFT : 0;
  // Wide enough that a left shift never loses bits that could land in the result.
  localparam int XW    = PW + WC + SHL;

  // Field widths follow the module parameters, so the stage type is declared here.
  typedef struct packed {
    logic          valid;
    logic [TW-1:0] tag;
    logic [WA-1:0] a;
    logic [WB-1:0] b;
  } stage_t;

  logic [TW-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt;
  logic [TW-1:0]    gnt_idx;
  logic             any_gnt;
  stage_t           issue_s, last_s;
  logic             pipe_busy;
  logic [N_REQ-1:0] resp_valid_q, resp_valid_d;
  logic [WC-1:0]    resp_c_q, resp_c_d;
  logic [PW-1:0]    prod;
  logic [XW-1:0]    prod_ext;
  logic [WC-1:0]    res_c;

  // Gating with rst keeps req_ready low for the whole reset assertion.
  svreal_rr_arbiter #(.N(N_REQ)) u_arb (
    .req_i     (bus.req_valid),
    .en_i      (bus.en & ~rst),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_gnt_o (any_gnt)
  );

  assign bus.req_ready = gnt;

  always_comb begin
    issue_s.valid = any_gnt;
    issue_s.tag   = gnt_idx;
    issue_s.a     = bus.req_a[int'(gnt_idx)*WA +: WA];
    issue_s.b     = bus.req_b[int'(gnt_idx)*WB +: WB];
  end

  // The output register is the final stage, so only MUL_LAT-1 internal stages exist.
  if (MUL_LAT == 1) begin : g_no_pipe
    assign last_s    = issue_s;
    assign pipe_busy = 1'b0;
  end else begin : g_pipe
    stage_t pipe_q [MUL_LAT-1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < MUL_LAT-1; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= issue_s;
        for (int i = 1; i < MUL_LAT-1; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign last_s = pipe_q[MUL_LAT-2];

    always_comb begin
      pipe_busy = 1'b0;
      for (int i = 0; i < MUL_LAT-1; i++) pipe_busy = pipe_busy | pipe_q[i].valid;
    end
  end

  // Full-width signed product, then a constant shift onto the result exponent.
  // >>> floors toward -inf; the WC cast wraps without saturation.
  assign prod     = PW'($signed(last_s.a) * $signed(last_s.b));
  assign prod_ext = {{(XW-PW){prod[PW-1]}}, prod};
  assign res_c    = WC'(($signed(prod_ext) >>> SHR) <<< SHL);

  always_comb begin
    ptr_d        = any_gnt ? gnt_idx : ptr_q;
    resp_valid_d = '0;
    resp_c_d     = resp_c_q;
    if (last_s.valid) begin
      resp_valid_d[last_s.tag] = 1'b1;
      resp_c_d                 = res_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= TW'(N_REQ-1);
      resp_valid_q <= '0;
      resp_c_q     <= '0;
    end else begin
      ptr_q        <= ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_c_q     <= resp_c_d;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_c     = resp_c_q;
  assign bus.busy       = pipe_busy | (|resp_valid_q);

endmodule

// File: tb/tb_svreal_mul_scheduler.sv
// Directed bench for svreal_mul_scheduler: default instance plus a MUL_LAT=1, EC=-4 instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_svreal_mul_scheduler;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  svreal_mul_scheduler_if #(.N_REQ(4), .WA(16), .WB(16), .WC(16)) bus  ();
  svreal_mul_scheduler_if #(.N_REQ(4), .WA(16), .WB(16), .WC(16)) bus6 ();

  svreal_mul_scheduler #(
    .N_REQ(4), .WA(16), .EA(-8), .WB(16), .EB(-8), .WC(16), .EC(-8), .MUL_LAT(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  svreal_mul_scheduler #(
    .N_REQ(4), .WA(16), .EA(-8), .WB(16), .EB(-8), .WC(16), .EC(-4), .MUL_LAT(1)
  ) dut6 (
    .clk (clk),
    .rst (rst),
    .bus (bus6)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    bus.req_a[i*16 +: 16] = a;
    bus.req_b[i*16 +: 16] = b;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b1;
    bus.req_valid = 4'hf;
    #2;
    checks++; if (bus.req_ready !== 4'h0) begin errors++; $display("FAIL reset_ready got=%h want=0", bus.req_ready); end
    step();
    checks++; if (bus.resp_valid !== 4'h0) begin errors++; $display("FAIL reset_resp_valid got=%h want=0", bus.resp_valid); end
    checks++; if (bus.resp_c !== 16'h0) begin errors++; $display("FAIL reset_resp_c got=%h want=0", bus.resp_c); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    bus.req_valid = 4'h0;
    rst = 1'b0;
  endtask

  task automatic test_single_op();
    set_op(0, 16'h0180, 16'h0200);
    bus.req_valid = 4'b0001;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got=%b want=0001", bus.req_ready); end
    step();
    bus.req_valid = 4'h0;
    checks++; if (bus.resp_valid !== 4'h0) begin errors++; $display("FAIL single_early_resp got=%b want=0000", bus.resp_valid); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy1 got=%b want=1", bus.busy); end
    step();
    checks++; if (bus.resp_valid !== 4'b0001) begin errors++; $display("FAIL single_resp_valid got=%b want=0001", bus.resp_valid); end
    checks++; if (bus.resp_c !== 16'h0300) begin errors++; $display("FAIL single_resp_c got=%h want=0300", bus.resp_c); end
    step();
    checks++; if (bus.resp_valid !== 4'h0) begin errors++; $display("FAIL single_pulse_len got=%b want=0000", bus.resp_valid); end
    checks++; if (bus.resp_c !== 16'h0300) begin errors++; $display("FAIL single_hold got=%h want=0300", bus.resp_c); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got=%b want=0", bus.busy); end
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_rdy;
    logic [3:0]  exp_vld;
    logic [15:0] exp_c;
    apply_reset();
    // Requester i multiplies (i+1).0 by 2.0, giving (i+1)*2.0 = (i+1)<<9.
    for (int i = 0; i < 4; i++) set_op(i, 16'((i+1) << 8), 16'h0200);
    for (int k = 0; k < 10; k++) begin
      bus.req_valid = (k < 8) ? 4'hf : 4'h0;
      exp_rdy = (k < 8) ? 4'(1 << (k % 4)) : 4'h0;
      #1;
      checks++; if (bus.req_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant[%0d] got=%b want=%b", k, bus.req_ready, exp_rdy); end
      step();
      exp_vld = (k >= 1 && k <= 8) ? 4'(1 << ((k-1) % 4)) : 4'h0;
      checks++; if (bus.resp_valid !== exp_vld) begin errors++; $display("FAIL rr_resp_valid[%0d] got=%b want=%b", k, bus.resp_valid, exp_vld); end
      if (k >= 1 && k <= 8) begin
        exp_c = 16'((((k-1) % 4) + 1) << 9);
        checks++; if (bus.resp_c !== exp_c) begin errors++; $display("FAIL rr_resp_c[%0d] got=%h want=%h", k, bus.resp_c, exp_c); end
      end
      checks++; if (bus.busy !== (k <= 8)) begin errors++; $display("FAIL rr_busy[%0d] got=%b want=%b", k, bus.busy, (k <= 8)); end
    end
  endtask

  task automatic test_neg_wrap();
    // Pointer is at 3 after the round-robin burst.
    set_op(2, 16'hFF80, 16'h0001);
    bus.req_valid = 4'b0100;
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL neg_ready got=%b want=0100", bus.req_ready); end
    step();
    set_op(3, 16'h7FFF, 16'h7FFF);
    bus.req_valid = 4'b1000;
    #1;
    checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_ready got=%b want=1000", bus.req_ready); end
    step();
    bus.req_valid = 4'h0;
    checks++; if (bus.resp_valid !== 4'b0100) begin errors++; $display("FAIL neg_resp_valid got=%b want=0100", bus.resp_valid); end
    checks++; if (bus.resp_c !== 16'hFFFF) begin errors++; $display("FAIL neg_floor got=%h want=FFFF", bus.resp_c); end
    step();
    checks++; if (bus.resp_valid !== 4'b1000) begin errors++; $display("FAIL wrap_resp_valid got=%b want=1000", bus.resp_valid); end
    checks++; if (bus.resp_c !== 16'hFF00) begin errors++; $display("FAIL wrap_value got=%h want=FF00", bus.resp_c); end
    step();
  endtask

  task automatic test_en_gate();
    set_op(1, 16'h0100, 16'h0300);
    set_op(2, 16'hFE00, 16'h0180);
    bus.en = 1'b1;
    bus.req_valid = 4'b0110;
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL en_grant1 got=%b want=0010", bus.req_ready); end
    step();
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL en_grant2 got=%b want=0100", bus.req_ready); end
    step();
    checks++; if (bus.resp_valid !== 4'b0010) begin errors++; $display("FAIL en_resp1_valid got=%b want=0010", bus.resp_valid); end
    checks++; if (bus.resp_c !== 16'h0300) begin errors++; $display("FAIL en_resp1_c got=%h want=0300", bus.resp_c); end
    bus.en = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL en_off_ready got=%b want=0000", bus.req_ready); end
    step();
    checks++; if (bus.resp_valid !== 4'b0100) begin errors++; $display("FAIL en_resp2_valid got=%b want=0100", bus.resp_valid); end
    checks++; if (bus.resp_c !== 16'hFD00) begin errors++; $display("FAIL en_resp2_c got=%h want=FD00", bus.resp_c); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL en_busy_last got=%b want=1", bus.busy); end
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL en_off_ready2 got=%b want=0000", bus.req_ready); end
    step();
    checks++; if (bus.resp_valid !== 4'b0000) begin errors++; $display("FAIL en_drained got=%b want=0000", bus.resp_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL en_busy_drop got=%b want=0", bus.busy); end
    bus.en = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL en_resume got=%b want=0010", bus.req_ready); end
    step();
    bus.req_valid = 4'h0;
    step();
    step();
    step();
  endtask

  task automatic test_async_reset();
    // Pointer is at 1: requesters 2 then 3 are granted.
    bus.req_valid = 4'hf;
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL ar_grant1 got=%b want=0100", bus.req_ready); end
    step();
    step();
    checks++; if (bus.resp_valid !== 4'b0100) begin errors++; $display("FAIL ar_inflight got=%b want=0100", bus.resp_valid); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.resp_valid !== 4'h0) begin errors++; $display("FAIL ar_resp_valid got=%b want=0000", bus.resp_valid); end
    checks++; if (bus.resp_c !== 16'h0) begin errors++; $display("FAIL ar_resp_c got=%h want=0000", bus.resp_c); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ar_busy got=%b want=0", bus.busy); end
    checks++; if (bus.req_ready !== 4'h0) begin errors++; $display("FAIL ar_ready got=%b want=0000", bus.req_ready); end
    step();
    rst = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL ar_first_grant got=%b want=0001", bus.req_ready); end
    bus.req_valid = 4'h0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (bus.resp_valid !== 4'h0) begin errors++; $display("FAIL ar_ghost[%0d] got=%b want=0000", k, bus.resp_valid); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ar_ghost_busy[%0d] got=%b want=0", k, bus.busy); end
    end
  endtask

  task automatic test_lat1();
    // s = -4 - (-16) = 12: 0x400*0x400 = 0x100000, >>12 = 0x0100 (4.0*4.0 = 16.0 at 2**-4).
    bus6.en = 1'b1;
    bus6.req_a[15:0] = 16'h0400;
    bus6.req_b[15:0] = 16'h0400;
    bus6.req_valid = 4'b0001;
    #1;
    checks++; if (bus6.req_ready !== 4'b0001) begin errors++; $display("FAIL lat1_ready got=%b want=0001", bus6.req_ready); end
    step();
    bus6.req_valid = 4'h0;
    checks++; if (bus6.resp_valid !== 4'b0001) begin errors++; $display("FAIL lat1_resp_valid got=%b want=0001", bus6.resp_valid); end
    checks++; if (bus6.resp_c !== 16'h0100) begin errors++; $display("FAIL lat1_resp_c got=%h want=0100", bus6.resp_c); end
    checks++; if (bus6.busy !== 1'b1) begin errors++; $display("FAIL lat1_busy got=%b want=1", bus6.busy); end
    step();
    checks++; if (bus6.resp_valid !== 4'h0) begin errors++; $display("FAIL lat1_pulse got=%b want=0000", bus6.resp_valid); end
    checks++; if (bus6.busy !== 1'b0) begin errors++; $display("FAIL lat1_busy_end got=%b want=0", bus6.busy); end
  endtask

  initial begin
    rst = 1'b1;
    bus.en = 1'b0;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus6.en = 1'b0;
    bus6.req_valid = '0;
    bus6.req_a = '0;
    bus6.req_b = '0;
    test_reset();
    test_single_op();
    test_round_robin();
    test_neg_wrap();
    test_en_gate();
    test_async_reset();
    test_lat1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
